prio_encoder_8to3_seq: RTL and testbench
========================================

# prio_encoder_8to3_seq

Registered 8-to-3 encoder with a request-accumulation register. Request bits are captured into a pending register. One pending bit per cycle is encoded onto a 3-bit code under a valid/ready handshake, and that bit is then cleared. The block is the encoder-side counterpart to the 3-to-8 decoder: each code it emits, decoded by the 3-to-8 decoder, regenerates the one-hot request line that was serviced.

## Interface
- WIDTH, 8, number of request lines; must be a power of two and at least 2.
- CODE_W, $clog2(WIDTH) = 3, code width; localparam, derived, never overridden.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  request capture enable; when 0, req_in is ignored.
- req_in  in  WIDTH  request lines, sampled each rising edge when en=1.
- code_out  out  CODE_W  encoded index of the serviced request.
- code_valid  out  1  code_out holds a valid code.
- code_ready  in  1  consumer accepts code_out this cycle.
- pend  out  WIDTH  pending-request register, exported for debug.
- idle  out  1  high when pend==0 and code_valid==0 (combinational).

## Operation
- Pending register update on each edge: pend <= (pend & ~grant_mask) | (en ? req_in : 0).
  - grant_mask is one-hot for the bit loaded into the output this cycle, otherwise 0.
  - A new request on the bit being granted in the same cycle wins; that bit stays set.
- Output slot is free when code_valid==0, or when code_valid==1 and code_ready==1.
- When the slot is free and pend!=0:
  - Pick one bit of pend (selection rule below).
  - code_out <= its index; code_valid <= 1; that bit's position goes on grant_mask.
- When the slot is free and pend==0: code_valid <= 0; code_out holds its last value.
- While code_valid==1 and code_ready==0:
  - code_out and code_valid stay stable.
  - No grant is made; pend only accumulates new requests.
- Requests already pending are OR-merged; duplicates are not counted (one pending bit per line).
- Selection rule (default): fixed priority, highest index wins (bit 7 over bit 0).
- State elements: pend, code_out, code_valid, plus the last-grant pointer when ROUND_ROBIN_EN is defined. There is no other FSM.

## Timing
- Reset (rst=1 at an edge) sets: pend=0, code_out=0, code_valid=0, idle=1, last-grant pointer=0.
  - Reset overrides en and req_in in the same cycle.
  - Reset mid-transfer drops the held code and all pending bits without a handshake.
- Latency: req_in sampled at edge N sets pend after edge N; code_valid rises after edge N+1 (2 edges), assuming the slot is free.
- Throughput: one code per cycle while code_ready=1 and pend!=0.
- A transfer completes on any edge where code_valid==1 and code_ready==1.
- code_ready may be asserted while code_valid==0; it has no effect.
- en=0 blocks capture only. Pending bits continue to drain.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority.
  - last_grant register, CODE_W bits, updated with each grant's index.
  - Search runs downward from last_grant-1, wrapping from 0 to WIDTH-1; last_grant itself is checked last.
  - Reset value 0, so the first search starts at bit 7, matching fixed priority.
- ROUND_ROBIN_EN undefined: fixed highest-index priority. No pointer register exists.
- Interface and latency are identical in both builds.

## Structure
- Package enc_pkg holds:
  - the default WIDTH constant;
  - the CODE_W derivation;
  - a function onehot_of(index) used for grant_mask.
- One sub-module, prio_pick: purely combinational.
  - Inputs: pend, start index.
  - Outputs: found flag and selected index.
  - Fixed-priority build ties the start index to WIDTH-1.
- The top level contains only the pend/output registers, the handshake, and the optional pointer.

## Test plan
- Reset: rst=1 for 2 cycles with req_in=8'hFF, en=1 -> code_valid=0, code_out=0, pend=0, idle=1.
- Burst: en=1, req_in=8'b1001_0010 for one cycle, code_ready=1 -> code_valid high after the 2nd edge; codes 7, 4, 1 on consecutive cycles; then idle=1.
- Enable gating: en=0, req_in=8'hFF for 5 cycles -> code_valid stays 0 and pend stays 0.
- Backpressure: pend holds bit 5, code_ready=0 for 4 cycles, then bit 2 requested -> code_out=5 held stable throughout; on code_ready=1, next code is 2.
- Same-cycle re-request: req_in=8'h80 held, code_ready=1 -> fixed build emits 7 every cycle.
  - Run the same stimulus in both builds; only the fixed build is checked against this result.
  - ROUND_ROBIN_EN build with req_in=8'hFF held -> emits 7,6,5,4,3,2,1,0,7.
- Reset mid-operation: rst during code_valid=1, code_ready=0 with pend=8'h0F -> next cycle code_valid=0, pend=0; no stale code after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package enc_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CODE_W = $clog2(DEF_WIDTH);

  function automatic int code_w(input int w);
    return $clog2(w);
  endfunction

  // Wide one-hot; callers size-cast down to their own WIDTH.
  function automatic logic [63:0] onehot_of(input int unsigned idx);
    return 64'd1 << idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational search of pend, walking downward from start with wrap-around.
module prio_pick #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3
) (
  input  logic [WIDTH-1:0]  pend,
  input  logic [CODE_W-1:0] start,
  output logic              found,
  output logic [CODE_W-1:0] idx
);

  logic [CODE_W-1:0] j;

  // WIDTH is a power of two, so CODE_W-bit subtraction wraps 0 -> WIDTH-1.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < WIDTH; k++) begin
      j = start - CODE_W'(k);
      if (!found && pend[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_8to3_seq.sv
// Registered 8-to-3 encoder with request accumulation and valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority; default is highest index first.
module prio_encoder_8to3_seq
  import enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         req_in,
  output logic [code_w(WIDTH)-1:0] code_out,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [WIDTH-1:0]         pend,
  output logic                     idle
);

  localparam int CODE_W = code_w(WIDTH);

  logic              slot_free, found, grant;
  logic [CODE_W-1:0] start, pick_idx;
  logic [WIDTH-1:0]  grant_mask;

  prio_pick #(.WIDTH(WIDTH), .CODE_W(CODE_W)) u_pick (
    .pend  (pend),
    .start (start),
    .found (found),
    .idx   (pick_idx)
  );

  assign slot_free  = !code_valid || code_ready;
  assign grant      = slot_free && found;
  assign grant_mask = grant ? WIDTH'(onehot_of(32'(pick_idx))) : '0;
  assign idle       = (pend == '0) && !code_valid;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_grant;

  always_ff @(posedge clk) begin
    if (rst)        last_grant <= '0;
    else if (grant) last_grant <= pick_idx;
  end

  // last_grant itself is visited last in the downward walk.
  assign start = last_grant - CODE_W'(1);
`else
  assign start = CODE_W'(WIDTH - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
    end else begin
      // A fresh request on the granted line re-sets it after the clear.
      pend <= (pend & ~grant_mask) | (en ? req_in : '0);
      if (slot_free) begin
        code_valid <= found;
        if (found) code_out <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_8to3_seq.sv
// Self-checking bench: directed scenarios plus random traffic vs a set-based model.
module tb_prio_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst, en, code_ready;
  logic [7:0] req_in;
  logic [2:0] code_out;
  logic       code_valid, idle;
  logic [7:0] pend;

  int checks = 0;
  int errors = 0;

  // Reference state: set of pending lines, held output, rotation pointer.
  bit m_set[8];
  int m_code, m_valid, m_last;

  always #5 clk = ~clk;

  prio_encoder_8to3_seq dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_in     (req_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pend       (pend),
    .idle       (idle)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_pick();
    int idx;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      idx = (m_last - k + 16) % 8;
      if (m_set[idx]) return idx;
    end
`else
    for (idx = 7; idx >= 0; idx--)
      if (m_set[idx]) return idx;
`endif
    return -1;
  endfunction

  function automatic int m_pend_val();
    int v = 0;
    for (int i = 0; i < 8; i++) if (m_set[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_edge();
    int sel;
    if (rst) begin
      foreach (m_set[i]) m_set[i] = 0;
      m_code = 0; m_valid = 0; m_last = 0;
      return;
    end
    sel = -1;
    if (!m_valid || code_ready) begin
      sel = m_pick();
      if (sel >= 0) begin
        m_code = sel; m_valid = 1; m_last = sel;
      end else m_valid = 0;
    end
    if (sel >= 0) m_set[sel] = 0;
    if (en) for (int i = 0; i < 8; i++) if (req_in[i]) m_set[i] = 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", int'(code_valid), m_valid);
    chk("code",  int'(code_out), m_code);
    chk("pend",  int'(pend), m_pend_val());
    chk("idle",  int'(idle), (m_pend_val() == 0 && m_valid == 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1; en = 1; req_in = 8'hFF; code_ready = 0;
    step(); step();
    rst = 0; en = 0; req_in = 0;
  endtask

  initial begin
    rst = 1; en = 1; req_in = 8'hFF; code_ready = 0;
    m_code = 0; m_valid = 0; m_last = 0;
    #2;

    // Reset with requests asserted
    do_reset();
    chk("rst_valid", int'(code_valid), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_idle", int'(idle), 1);

    // Burst: 7, 4, 1 back-to-back
    code_ready = 1; en = 1; req_in = 8'b1001_0010;
    step();
    chk("burst_lat", int'(code_valid), 0);
    en = 0; req_in = 0;
    step(); chk("burst_c7", int'(code_out), 7); chk("burst_v", int'(code_valid), 1);
    step(); chk("burst_c4", int'(code_out), 4);
    step(); chk("burst_c1", int'(code_out), 1);
    step(); chk("burst_idle", int'(idle), 1);

    // Enable gating
    en = 0; req_in = 8'hFF;
    repeat (5) begin
      step(); chk("gate_valid", int'(code_valid), 0); chk("gate_pend", int'(pend), 0);
    end
    req_in = 0;

    // Backpressure: 5 held, 2 arrives, then released
    code_ready = 0; en = 1; req_in = 8'h20;
    step(); en = 0; req_in = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin en = 1; req_in = 8'h04; end
      else begin en = 0; req_in = 0; end
      step(); chk("bp_hold", int'(code_out), 5); chk("bp_valid", int'(code_valid), 1);
    end
    en = 0; req_in = 0; code_ready = 1;
    step(); chk("bp_next", int'(code_out), 2);
    step(); step();

    // Same-cycle re-request
    en = 1; req_in = 8'h80;
    step();
    repeat (6) begin
      step();
`ifndef ROUND_ROBIN_EN
      chk("rereq_c7", int'(code_out), 7);
`endif
    end
    en = 0; req_in = 0; step(); step();

`ifdef ROUND_ROBIN_EN
    do_reset();
    code_ready = 1; en = 1; req_in = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      step(); chk("rr_seq", int'(code_out), (7 - k + 8) % 8);
    end
    en = 0; req_in = 0; repeat (10) step();
`endif

    // Reset while holding a code with pend=0F
    code_ready = 0; en = 1; req_in = 8'h10;
    step(); en = 0; req_in = 0;
    step();
    en = 1; req_in = 8'h0F;
    step(); chk("mid_pend", int'(pend), 8'h0F);
    rst = 1; en = 1; req_in = 8'hFF;
    step(); chk("mid_valid", int'(code_valid), 0); chk("mid_pend0", int'(pend), 0);
    rst = 0; en = 0; req_in = 0; code_ready = 1;
    step(); chk("mid_stale", int'(code_valid), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 99) == 0);
      en         = $urandom_range(0, 1);
      req_in     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      code_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
